sr_shift_ctrl: RTL and testbench

- Sequencer that sits directly upstream of the team's 32-bit parallel-load shift register.
- Accepts a parallel word with a valid/ready handshake, then drives the register's mode select, parallel data and fill bits: one load, then N shift cycles.
- Emits the shifted-out bit stream with its own valid/ready handshake, so a downstream serial consumer can stall it.
- Fully synchronous. One word in flight at a time.

---
 rtl/sr_pkg.sv | 21 ++
 rtl/sr_shift_ctrl_if.sv | 32 +++
 rtl/sr_shift_ctrl.sv | 108 ++++++++++
 tb/tb_sr_shift_ctrl.sv | 324 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/sr_pkg.sv
// Shared types for the shift-register sequencer and the 32-bit parallel-load register it drives.
package sr_pkg;

    localparam int SR_WIDTH = 32;

    // Select encoding understood by the shift register itself.
    typedef enum logic [1:0] {
        SR_HOLD = 2'b00,
        SR_LOAD = 2'b01,
        SR_SHL  = 2'b10,
        SR_SHR  = 2'b11
    } sr_mode_e;

    typedef enum logic [1:0] {
        IDLE  = 2'b00,
        LOAD  = 2'b01,
        SHIFT = 2'b10,
        DONE  = 2'b11
    } ctrl_state_e;

endpackage

// File: rtl/sr_shift_ctrl_if.sv
// Word-in and bit-out handshakes of the shift sequencer; master is the upstream/downstream side, slave is the sequencer.
interface sr_shift_ctrl_if
    import sr_pkg::*;
#(
    parameter int WIDTH = SR_WIDTH,
    parameter int LEN_W = $clog2(WIDTH + 1)
);

    // valid/ready: a beat transfers on a rising clk edge where valid && ready are both 1;
    // a producer never drops valid or changes its payload until that beat has transferred.
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] in_data;
    logic             in_dir;
    logic [LEN_W-1:0] in_len;
    logic             in_fill;

    logic             ser_out;
    logic             ser_valid;
    logic             ser_ready;

    modport master (
        output in_valid, in_data, in_dir, in_len, in_fill, ser_ready,
        input  in_ready, ser_out, ser_valid
    );

    modport slave (
        input  in_valid, in_data, in_dir, in_len, in_fill, ser_ready,
        output in_ready, ser_out, ser_valid
    );

endinterface

// File: rtl/sr_shift_ctrl.sv
// Sequencer for a parallel-load shift register: accepts a word, loads it, then shifts out N bits
// under downstream backpressure, pulsing done once the last bit has been taken.
module sr_shift_ctrl
    import sr_pkg::*;
#(
    parameter int WIDTH = SR_WIDTH,
    parameter int LEN_W = $clog2(WIDTH + 1)
) (
    input  logic             clk,
    input  logic             rst,
    sr_shift_ctrl_if.slave   bus,
    output sr_mode_e         sr_sel,
    output logic [WIDTH-1:0] sr_data,
    output logic             sr_il,
    output logic             sr_ir,
    input  logic             q_msb,
    input  logic             q_lsb,
    output logic             busy,
    output logic             done,
    output ctrl_state_e      state_dbg
);

    ctrl_state_e      state_q, state_d;
    logic [LEN_W-1:0] count_q, count_d;
    logic [WIDTH-1:0] data_q;
    logic             dir_q;
    logic             fill_q;
    logic [LEN_W-1:0] len_eff;
    logic             accept;

    // A zero or oversized length means a full word.
    always_comb begin
        len_eff = bus.in_len;
        if (bus.in_len == '0 || int'(bus.in_len) > WIDTH) begin
            len_eff = LEN_W'(WIDTH);
        end
    end

    assign accept = bus.in_valid && bus.in_ready;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            count_q <= '0;
            data_q  <= '0;
            dir_q   <= 1'b0;
            fill_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            count_q <= count_d;
            if (accept) begin
                data_q <= bus.in_data;
                dir_q  <= bus.in_dir;
                fill_q <= bus.in_fill;
            end
        end
    end

    always_comb begin
        state_d       = state_q;
        count_d       = count_q;
        sr_sel        = SR_HOLD;
        bus.in_ready  = 1'b0;
        bus.ser_valid = 1'b0;
        bus.ser_out   = 1'b0;
        busy          = 1'b0;
        done          = 1'b0;
        case (state_q)
            IDLE: begin
                bus.in_ready = !rst;
                if (bus.in_valid && !rst) begin
                    count_d = len_eff;
                    state_d = LOAD;
                end
            end
            LOAD: begin
                sr_sel  = SR_LOAD;
                busy    = 1'b1;
                state_d = SHIFT;
            end
            SHIFT: begin
                busy          = 1'b1;
                bus.ser_valid = 1'b1;
                // The presented bit is the one about to leave the register, so a stall holds it in place.
                bus.ser_out   = dir_q ? q_lsb : q_msb;
                if (bus.ser_ready) begin
                    sr_sel  = dir_q ? SR_SHR : SR_SHL;
                    count_d = count_q - LEN_W'(1);
                    if (count_q == LEN_W'(1)) begin
                        state_d = DONE;
                    end
                end
            end
            DONE: begin
                busy    = 1'b1;
                done    = 1'b1;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    assign sr_data   = data_q;
    assign sr_il     = fill_q;
    assign sr_ir     = fill_q;
    assign state_dbg = state_q;

endmodule

// File: tb/tb_sr_shift_ctrl.sv
// Directed bench for sr_shift_ctrl with a behavioural 32-bit shift register attached to its select/fill outputs.
module tb_sr_shift_ctrl;
    import sr_pkg::*;

    localparam int WIDTH = SR_WIDTH;
    localparam int LEN_W = $clog2(WIDTH + 1);

    logic             clk = 1'b0;
    logic             rst = 1'b1;
    sr_mode_e         sr_sel;
    logic [WIDTH-1:0] sr_data;
    logic             sr_il;
    logic             sr_ir;
    logic             q_msb;
    logic             q_lsb;
    logic             busy;
    logic             done;
    ctrl_state_e      state_dbg;

    sr_shift_ctrl_if #(.WIDTH(WIDTH), .LEN_W(LEN_W)) bus ();

    sr_shift_ctrl #(.WIDTH(WIDTH), .LEN_W(LEN_W)) dut (
        .clk       (clk),
        .rst       (rst),
        .bus       (bus),
        .sr_sel    (sr_sel),
        .sr_data   (sr_data),
        .sr_il     (sr_il),
        .sr_ir     (sr_ir),
        .q_msb     (q_msb),
        .q_lsb     (q_lsb),
        .busy      (busy),
        .done      (done),
        .state_dbg (state_dbg)
    );

    // ---------------- clock / reset / cycle counter ----------------
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // ---------------- attached shift register model ----------------
    logic [WIDTH-1:0] q_model = '0;
    always @(posedge clk) begin
        case (sr_sel)
            SR_LOAD: q_model <= sr_data;
            SR_SHL:  q_model <= {q_model[WIDTH-2:0], sr_ir};
            SR_SHR:  q_model <= {sr_il, q_model[WIDTH-1:1]};
            default: q_model <= q_model;
        endcase
    end
    assign q_msb = q_model[WIDTH-1];
    assign q_lsb = q_model[0];

    // ---------------- checking ----------------
    int checks = 0;
    int errors = 0;

    task automatic check(input string tag, input logic [WIDTH-1:0] got, input logic [WIDTH-1:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // ---------------- scoreboard for the serial stream ----------------
    logic [0:0] exp_q[$];
    logic       exp_dir  = 1'b0;
    int         beats    = 0;
    int         done_cnt = 0;
    int         done_cyc = 0;

    task automatic push_run(input logic b, input int n);
        for (int i = 0; i < n; i++) exp_q.push_back(b);
    endtask

    initial begin
        logic       stalled;
        logic       stall_bit;
        logic [0:0] exp_bit;
        stalled   = 1'b0;
        stall_bit = 1'b0;
        forever begin
            @(negedge clk);
            if (rst) begin
                stalled = 1'b0;
            end else begin
                if (bus.ser_valid) begin
                    if (bus.ser_ready) begin
                        check("shift_sel", WIDTH'(sr_sel), WIDTH'(exp_dir ? SR_SHR : SR_SHL));
                        check("bit_expected", WIDTH'(exp_q.size() != 0), 1);
                        if (exp_q.size() != 0) begin
                            exp_bit = exp_q.pop_front();
                            check("ser_bit", WIDTH'(bus.ser_out), WIDTH'(exp_bit));
                        end
                        if (stalled) check("stall_release_bit", WIDTH'(bus.ser_out), WIDTH'(stall_bit));
                        stalled = 1'b0;
                        beats++;
                    end else begin
                        check("stall_sel", WIDTH'(sr_sel), WIDTH'(SR_HOLD));
                        if (stalled) check("stall_bit_stable", WIDTH'(bus.ser_out), WIDTH'(stall_bit));
                        stalled   = 1'b1;
                        stall_bit = bus.ser_out;
                    end
                end
                if (done) begin
                    done_cnt++;
                    done_cyc = cyc;
                end
            end
        end
    end

    // ---------------- driver tasks ----------------
    task automatic drive_word(input logic [WIDTH-1:0] d, input logic dir, input logic [LEN_W-1:0] len,
                              input logic fill);
        bus.in_valid = 1'b1;
        bus.in_data  = d;
        bus.in_dir   = dir;
        bus.in_len   = len;
        bus.in_fill  = fill;
    endtask

    // Returns at the negedge of the cycle in which the word is accepted.
    task automatic wait_accept(output int acc);
        int n;
        n = 0;
        @(negedge clk);
        while (!bus.in_ready && n < 100) begin
            @(negedge clk);
            n++;
        end
        check("accept_timeout", WIDTH'(bus.in_ready), 1);
        acc = cyc;
    endtask

    task automatic wait_done(input int max);
        int n;
        int d0;
        n  = 0;
        d0 = done_cnt;
        while (done_cnt == d0 && n < max) begin
            @(negedge clk);
            n++;
        end
        check("done_timeout", WIDTH'(done_cnt != d0), 1);
    endtask

    // ---------------- directed tests ----------------
    initial begin
        int acc;
        int acc2;
        int b0;
        int d0;

        bus.in_valid  = 1'b1;
        bus.in_data   = 32'hDEAD_BEEF;
        bus.in_dir    = 1'b0;
        bus.in_len    = '0;
        bus.in_fill   = 1'b0;
        bus.ser_ready = 1'b1;

        // Reset hold with in_valid high
        @(posedge clk);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check("rst_in_ready", WIDTH'(bus.in_ready), 0);
            check("rst_sr_sel", WIDTH'(sr_sel), WIDTH'(SR_HOLD));
            check("rst_ser_valid", WIDTH'(bus.ser_valid), 0);
            check("rst_done", WIDTH'(done), 0);
        end
        check("rst_sr_data", sr_data, 0);
        check("rst_busy", WIDTH'(busy), 0);
        @(posedge clk); #1;
        rst          = 1'b0;
        bus.in_valid = 1'b0;
        @(negedge clk);
        check("post_rst_in_ready", WIDTH'(bus.in_ready), 1);

        // Left shift full word, len=0 means 32
        exp_dir = 1'b0;
        push_run(1'b1, 1);
        push_run(1'b0, 30);
        push_run(1'b1, 1);
        b0 = beats;
        d0 = done_cnt;
        @(posedge clk); #1;
        drive_word(32'h8000_0001, 1'b0, LEN_W'(0), 1'b0);
        wait_accept(acc);
        @(posedge clk); #1;
        bus.in_valid = 1'b0;
        @(negedge clk);
        check("load_sel", WIDTH'(sr_sel), WIDTH'(SR_LOAD));
        check("load_data", sr_data, 32'h8000_0001);
        check("load_busy", WIDTH'(busy), 1);
        check("load_in_ready", WIDTH'(bus.in_ready), 0);
        @(negedge clk);
        check("first_ser_valid", WIDTH'(bus.ser_valid), 1);
        wait_done(60);
        check("left_done_latency", WIDTH'(done_cyc - acc), 34);
        check("left_beats", WIDTH'(beats - b0), 32);
        check("left_done_count", WIDTH'(done_cnt - d0), 1);
        check("left_queue_empty", WIDTH'(exp_q.size()), 0);

        // Right shift partial, fill=1
        exp_dir = 1'b1;
        push_run(1'b1, 2);
        push_run(1'b0, 1);
        push_run(1'b1, 1);
        b0 = beats;
        d0 = done_cnt;
        @(posedge clk); #1;
        drive_word(32'h0000_000B, 1'b1, LEN_W'(4), 1'b1);
        wait_accept(acc);
        @(posedge clk); #1;
        bus.in_valid = 1'b0;
        wait_done(30);
        repeat (3) @(negedge clk);
        check("right_done_latency", WIDTH'(done_cyc - acc), 6);
        check("right_beats", WIDTH'(beats - b0), 4);
        check("right_done_once", WIDTH'(done_cnt - d0), 1);
        check("right_reg_value", q_model, 32'hF000_0000);
        check("right_fill_il", WIDTH'(sr_il), 1);
        check("right_idle_ser_valid", WIDTH'(bus.ser_valid), 0);

        // Backpressure: len=3, stall 5 cycles from the 2nd shift cycle
        exp_dir = 1'b0;
        push_run(1'b1, 1);
        push_run(1'b0, 1);
        push_run(1'b1, 1);
        b0 = beats;
        @(posedge clk); #1;
        drive_word(32'hA000_0000, 1'b0, LEN_W'(3), 1'b0);
        wait_accept(acc);
        @(posedge clk); #1;
        bus.in_valid = 1'b0;
        @(posedge clk); #1;
        @(posedge clk); #1;
        bus.ser_ready = 1'b0;
        repeat (5) @(posedge clk);
        #1;
        bus.ser_ready = 1'b1;
        wait_done(30);
        check("bp_done_latency", WIDTH'(done_cyc - acc), 10);
        check("bp_beats", WIDTH'(beats - b0), 3);
        check("bp_queue_empty", WIDTH'(exp_q.size()), 0);

        // Back-to-back: in_valid held high across two words; second uses len>WIDTH
        exp_dir = 1'b0;
        push_run(1'b1, 2);
        push_run(1'b1, 16);
        push_run(1'b0, 16);
        b0 = beats;
        @(posedge clk); #1;
        drive_word(32'hC000_0000, 1'b0, LEN_W'(2), 1'b0);
        wait_accept(acc);
        @(posedge clk); #1;
        drive_word(32'h0000_FFFF, 1'b1, LEN_W'(33), 1'b0);
        wait_accept(acc2);
        exp_dir = 1'b1;
        check("b2b_first_done", WIDTH'(done_cyc - acc), 4);
        check("b2b_second_accept", WIDTH'(acc2 - acc), 5);
        @(posedge clk); #1;
        bus.in_valid = 1'b0;
        wait_done(60);
        check("b2b_second_done", WIDTH'(done_cyc - acc2), 34);
        check("b2b_beats", WIDTH'(beats - b0), 34);
        check("b2b_queue_empty", WIDTH'(exp_q.size()), 0);

        // Mid-word reset during the 5th SHIFT cycle
        exp_dir = 1'b0;
        push_run(1'b1, 4);
        b0 = beats;
        d0 = done_cnt;
        @(posedge clk); #1;
        drive_word(32'hFFFF_FFFF, 1'b0, LEN_W'(0), 1'b0);
        wait_accept(acc);
        @(posedge clk); #1;
        bus.in_valid = 1'b0;
        repeat (5) @(posedge clk);
        #1;
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        @(negedge clk);
        check("abort_sr_sel", WIDTH'(sr_sel), WIDTH'(SR_HOLD));
        check("abort_ser_valid", WIDTH'(bus.ser_valid), 0);
        check("abort_busy", WIDTH'(busy), 0);
        check("abort_in_ready", WIDTH'(bus.in_ready), 1);
        check("abort_state", WIDTH'(state_dbg), WIDTH'(IDLE));
        repeat (40) @(negedge clk);
        check("abort_no_done", WIDTH'(done_cnt - d0), 0);
        check("abort_beats", WIDTH'(beats - b0), 4);
        check("abort_queue_empty", WIDTH'(exp_q.size()), 0);

        // Recovery word after the abort
        exp_dir = 1'b1;
        push_run(1'b0, 1);
        push_run(1'b1, 1);
        b0 = beats;
        @(posedge clk); #1;
        drive_word(32'h0000_0002, 1'b1, LEN_W'(2), 1'b0);
        wait_accept(acc);
        @(posedge clk); #1;
        bus.in_valid = 1'b0;
        wait_done(30);
        check("recover_done_latency", WIDTH'(done_cyc - acc), 4);
        check("recover_beats", WIDTH'(beats - b0), 2);
        check("recover_fill_ir", WIDTH'(sr_ir), 0);

        repeat (2) @(negedge clk);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
